// File: rtl/puf_pkg.sv
// Shared definitions for the PUF Hamming-distance scheduler.
package puf_pkg;

  localparam int unsigned RespW = 128;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} hd_state_t;

  function automatic int unsigned npair(int unsigned n);
    return n * (n - 1) / 2;
  endfunction

endpackage

// File: rtl/hd_popcount.sv
// Two-stage XOR/popcount datapath: per-16-bit chunk counts, then a registered sum.
module hd_popcount #(
  parameter int unsigned RESP_W = 128,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned CNT_W  = $clog2(RESP_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RESP_W-1:0] a,
  input  logic [RESP_W-1:0] b,
  input  logic              in_valid,
  input  logic [IDX_W-1:0]  in_i,
  input  logic [IDX_W-1:0]  in_j,
  output logic [CNT_W-1:0]  hd,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_i,
  output logic [IDX_W-1:0]  out_j
);

  localparam int unsigned NChunk = (RESP_W + 15) / 16;
  localparam int unsigned PadW   = NChunk * 16;

  logic [PadW-1:0] diff;
  logic [4:0]      chunk_d [NChunk];
  logic [4:0]      chunk_q [NChunk];
  logic            v1_q;
  logic [IDX_W-1:0] i1_q, j1_q;
  logic [CNT_W-1:0] sum_d;

  always_comb begin
    diff = '0;
    diff[RESP_W-1:0] = a ^ b;
    for (int c = 0; c < NChunk; c++) begin
      chunk_d[c] = '0;
      for (int bit_idx = 0; bit_idx < 16; bit_idx++) begin
        chunk_d[c] = chunk_d[c] + 5'(diff[c*16+bit_idx]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NChunk; c++) chunk_q[c] <= '0;
      v1_q <= 1'b0;
      i1_q <= '0;
      j1_q <= '0;
    end else begin
      for (int c = 0; c < NChunk; c++) chunk_q[c] <= chunk_d[c];
      v1_q <= in_valid;
      i1_q <= in_i;
      j1_q <= in_j;
    end
  end

  always_comb begin
    sum_d = '0;
    for (int c = 0; c < NChunk; c++) sum_d = sum_d + CNT_W'(chunk_q[c]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd        <= '0;
      out_valid <= 1'b0;
      out_i     <= '0;
      out_j     <= '0;
    end else begin
      hd        <= sum_d;
      out_valid <= v1_q;
      out_i     <= i1_q;
      out_j     <= j1_q;
    end
  end

endmodule

// File: rtl/puf_hd_scheduler.sv
// Buffers a batch of PUF responses and streams the Hamming distance of every pair,
// accumulating sum/min/max statistics on-chip.
module puf_hd_scheduler
  import puf_pkg::*;
#(
  parameter int unsigned RESP_W = RespW,
  parameter int unsigned N_RESP = 8,
  parameter int unsigned CNT_W  = $clog2(RESP_W + 1),
  parameter int unsigned NPAIR  = npair(N_RESP),
  parameter int unsigned SUM_W  = $clog2(NPAIR * RESP_W + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [RESP_W-1:0]         in_data,
  output logic                      in_ready,
  input  logic                      start,
  output logic                      busy,
  output logic                      pair_valid,
  output logic [$clog2(N_RESP)-1:0] pair_i,
  output logic [$clog2(N_RESP)-1:0] pair_j,
  output logic [CNT_W-1:0]          pair_hd,
  output logic                      done,
  output logic [SUM_W-1:0]          hd_sum,
  output logic [CNT_W-1:0]          hd_min,
  output logic [CNT_W-1:0]          hd_max
);

  localparam int unsigned IDX_W = $clog2(N_RESP);
  localparam int unsigned PTR_W = $clog2(N_RESP + 1);
  localparam logic [PTR_W-1:0] PtrFull   = PTR_W'(N_RESP);
  localparam logic [IDX_W-1:0] IdxLast   = IDX_W'(N_RESP - 1);
  localparam logic [IDX_W-1:0] IdxPenult = IDX_W'(N_RESP - 2);

  hd_state_t        state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [IDX_W-1:0] idx_i_q, idx_i_d, idx_j_q, idx_j_d;
  logic             drain_q, drain_d;
  logic [RESP_W-1:0] resp_q [N_RESP];
  logic             wr_en, start_ok;

  assign in_ready = (state_q == IDLE) && (wr_ptr_q < PtrFull);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign wr_en    = in_valid && in_ready;
  assign start_ok = (state_q == IDLE) && start && (wr_ptr_q == PtrFull);

  always_comb begin
    state_d = state_q;
    idx_i_d = idx_i_q;
    idx_j_d = idx_j_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = RUN;
          idx_i_d = '0;
          idx_j_d = IDX_W'(1);
        end
      end
      RUN: begin
        if (idx_i_q == IdxPenult && idx_j_q == IdxLast) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else if (idx_j_q == IdxLast) begin
          idx_i_d = idx_i_q + IDX_W'(1);
          idx_j_d = idx_i_q + IDX_W'(2);
        end else begin
          idx_j_d = idx_j_q + IDX_W'(1);
        end
      end
      // Two cycles lets the last issued pair leave the datapath.
      DRAIN: begin
        if (drain_q) state_d = DONE;
        else         drain_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      idx_i_q  <= '0;
      idx_j_q  <= '0;
      drain_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_i_q  <= idx_i_d;
      idx_j_q  <= idx_j_d;
      drain_q  <= drain_d;
      if (state_q == DONE) wr_ptr_q <= '0;
      else if (wr_en)      wr_ptr_q <= wr_ptr_q + PTR_W'(1);
    end
  end

  // Response storage needs no reset: wr_ptr gates what is considered valid.
  always_ff @(posedge clk) begin
    if (wr_en) resp_q[wr_ptr_q[IDX_W-1:0]] <= in_data;
  end

  hd_popcount #(
    .RESP_W (RESP_W),
    .IDX_W  (IDX_W),
    .CNT_W  (CNT_W)
  ) u_popcount (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (resp_q[idx_i_q]),
    .b         (resp_q[idx_j_q]),
    .in_valid  (state_q == RUN),
    .in_i      (idx_i_q),
    .in_j      (idx_j_q),
    .hd        (pair_hd),
    .out_valid (pair_valid),
    .out_i     (pair_i),
    .out_j     (pair_j)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd_sum <= '0;
      hd_min <= CNT_W'(RESP_W);
      hd_max <= '0;
    end else if (start_ok) begin
      hd_sum <= '0;
      hd_min <= CNT_W'(RESP_W);
      hd_max <= '0;
    end else if (pair_valid) begin
      hd_sum <= hd_sum + SUM_W'(pair_hd);
      if (pair_hd < hd_min) hd_min <= pair_hd;
      if (pair_hd > hd_max) hd_max <= pair_hd;
    end
  end

endmodule

// File: doc/puf_hd_scheduler.md
# puf_hd_scheduler

Batch controller for PUF uniqueness and reliability measurement. It buffers `N_RESP` PUF responses of `RESP_W` bits each. On `start` it schedules every unordered pair (i<j) through one shared pipelined XOR/popcount datapath, streams out the Hamming distance of each pair, and accumulates sum, min and max. It sits between the PUF response capture logic and the UART/reporting path, so HD statistics are computed on-chip rather than offline.

## Interface
- `RESP_W`, 128, response width in bits
- `N_RESP`, 8, responses per batch (≥2)
- `CNT_W`, $clog2(RESP_W+1), width of one pair HD
- `NPAIR`, N_RESP*(N_RESP-1)/2, pairs per batch (28 at defaults)
- `SUM_W`, $clog2(NPAIR*RESP_W+1), accumulator width
- `clk` in 1 — single clock, all logic rising-edge
- `rst_n` in 1 — reset, asynchronous assert, active-low
- `in_valid` in 1 — response write request
- `in_data` in RESP_W — response to store
- `in_ready` out 1 — buffer accepts `in_data`
- `start` in 1 — begin pairwise evaluation
- `busy` out 1 — evaluation in progress
- `pair_valid` out 1 — one-cycle strobe, per-pair result valid
- `pair_i`, `pair_j` out $clog2(N_RESP) — indices of reported pair
- `pair_hd` out CNT_W — popcount(resp[i] ^ resp[j])
- `done` out 1 — one-cycle pulse, batch complete
- `hd_sum` out SUM_W; `hd_min`, `hd_max` out CNT_W — batch statistics

## Operation
- FSM: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE:
  - `in_ready` = (wr_ptr < N_RESP).
  - Transfer on `in_valid && in_ready`: store at wr_ptr, then wr_ptr++.
  - `start` is accepted only when wr_ptr == N_RESP. Otherwise it is ignored with no state change.
- Accepted `start`:
  - Set hd_sum=0, hd_min=RESP_W, hd_max=0, i=0, j=1.
  - Go to RUN.
- RUN:
  - Issue pair (i,j) into the datapath every cycle, with no bubbles.
  - Order: i outer 0..N_RESP-2, j inner i+1..N_RESP-1.
  - After issuing (N_RESP-2, N_RESP-1), go to DRAIN.
- DRAIN:
  - Wait until the datapath pipeline is empty (2 cycles), then go to DONE.
- DONE:
  - Assert `done` for one cycle.
  - Clear wr_ptr to 0 so the buffer is free for the next batch.
  - Go to IDLE.
- Each `pair_valid`:
  - hd_sum += pair_hd.
  - hd_min = min(hd_min, pair_hd); hd_max = max(hd_max, pair_hd).
  - A result arriving in the same cycle as the FSM state change is still counted.
- `in_ready` = 0 in RUN, DRAIN and DONE.
- `start` is ignored while `busy` is high.
- Statistics hold their value after `done` until the next accepted `start`.
- Stored responses are never modified during a batch.

## Timing
- Reset values:
  - FSM IDLE, wr_ptr 0.
  - `in_ready` 1, `busy` 0, `pair_valid` 0, `done` 0.
  - `pair_i`/`pair_j`/`pair_hd` 0, `hd_sum` 0, `hd_min` RESP_W, `hd_max` 0.
- Reset mid-batch aborts immediately. No `done` is produced and the buffer is emptied.
- `start` sampled at edge T. Pair k (0-based) is issued in cycle T+1+k, and its `pair_valid` appears in cycle T+3+k (datapath latency 2).
- `done` is high in cycle T+NPAIR+3, which is T+31 at defaults. `busy` is high in cycles T+1..T+NPAIR+3.
- Accumulators are updated in the cycle after `pair_valid`. They are final when `done` is high.
- Datapath latency is fixed: no stalls, no backpressure on the result stream.

## Structure
- Shared package `puf_pkg`:
  - `RESP_W` default.
  - `hd_state_t` enum {IDLE, RUN, DRAIN, DONE}.
  - `npair(n)` constant function.
- Sub-module `hd_popcount` (parameter `RESP_W`). Ports: clk, rst_n, a, b, in_valid, idx tags; outputs hd, out_valid, tags.
  - Stage 1: XOR, then popcount each 16-bit chunk, registered.
  - Stage 2: adder tree of the chunk counts, registered.
- The controller owns the response buffer (register array), the pair-index counters, the FSM and the accumulators.

## Test plan
- Load resp[k] = (1<<k)-1 for k=0..7, then pulse `start` → 28 `pair_valid` strobes in order (0,1)…(6,7), each with pair_hd = j-i; `hd_sum`=84, `hd_min`=1, `hd_max`=7; `done` at T+31.
- Eight identical responses 0xA5…A5 → every pair_hd=0, `hd_sum`=0, `hd_min`=0, `hd_max`=0.
- Alternate all-zeros / all-ones (even k zeros) → the 16 pairs with mismatched parity report 128 and the 12 same-parity pairs report 0; `hd_sum`=2048, `hd_min`=0, `hd_max`=128.
- Load 5 responses, then pulse `start` → ignored, `busy` stays 0. Load 3 more, pulse `start` → batch runs normally. Hold `in_valid` high during RUN → no writes, `in_ready`=0 until after `done`.
- Deassert `rst_n` at T+10 of a batch → all outputs return to reset values asynchronously, no `done`. After release, 8 new loads and `start` give correct results.
